csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Initiator side of the core's CSR file interface: executes Zicsr instructions (CSRRW/S/C and immediate forms) as a read-modify-write sequence against the CSR file. It sits between the execute stage and the CSR file, takes one decoded request at a time over a valid/ready handshake, and returns the old CSR value plus an illegal-instruction flag. It decides whether each access is legal and whether the write half is suppressed.

## Interface
- XLEN, 32, data width of CSR values and rs1 operand
- ADDR_W, 12, CSR address width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 invalid
- req_addr  in  ADDR_W  CSR address (instr[31:20])
- req_src  in  XLEN  rs1 value (register forms)
- req_uimm  in  5  zimm (immediate forms; also rs1 index for register forms)
- req_rd_zero  in  1  destination register is x0
- csr_addr  out  ADDR_W  address driven to CSR file
- csr_re  out  1  read strobe
- csr_we  out  1  write strobe, one-cycle pulse
- csr_wd  out  XLEN  write data
- csr_rd  in  XLEN  combinational read data for csr_addr
- csr_hit  in  1  csr_addr is implemented
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  XLEN  old CSR value (0 when illegal)
- rsp_illegal  out  1  raise illegal-instruction exception

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch op, addr, operand (req_src, or zero-extended req_uimm for xxI), uimm, rd_zero; go READ.
- READ: csr_addr=latched addr; csr_re=1 unless op is RW/RWI with rd_zero. Sample csr_rd into old; compute illegal and new value; go WRITE if write enabled and legal, else RESP.
- Write enable: RW/RWI always; RS/RC/RSI/RCI only when latched uimm != 0.
- New value: RW* = operand; RS* = old | operand; RC* = old & ~operand.
- Illegal when any: op is 000 or 100; csr_hit=0; write enabled and addr[11:10]==2'b11 (read-only space, see Configuration). Illegal access issues no write; rsp_rdata=0.
- WRITE: csr_we=1, csr_wd=new value, csr_addr=latched addr; go RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_illegal stable; on rsp_ready go IDLE.
- csr_re, csr_we, csr_wd are 0 outside READ/WRITE; csr_addr holds latched addr.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_illegal=0; csr_re=0; csr_we=0; csr_wd=0; csr_addr=0.
- Request accepted at edge N (req_valid & req_ready). READ during cycle N+1, WRITE N+2, rsp_valid from N+3 (legal write). No-write or illegal: rsp_valid from N+2.
- rsp_valid held with stable data until rsp_ready; acceptance and new request cannot coincide (req_ready=0 in RESP). Earliest next acceptance one cycle after response handshake; throughput one op per 4 cycles minimum.
- csr_we asserted exactly one cycle per legal write op, never on illegal ops.
- rst asserted mid-operation: immediate return to IDLE, all outputs to reset values; any pending write is dropped (no partial write if rst precedes the WRITE edge).
- Read and write within one op use the same latched address; csr_rd sampled only in READ.

## Configuration
- CSR_RO_CHECK_EN defined: write-enabled access to addr[11:10]==2'b11 flags rsp_illegal and suppresses the write.
- Not defined: no read-only check; such writes are issued to the CSR file, which ignores them; rsp_illegal depends only on op validity and csr_hit.

## Test plan
- Reset, then CSRRW addr 0x340, src 0xDEADBEEF, csr_rd 0x12345678, hit=1 -> csr_we pulse at N+2 with wd 0xDEADBEEF, rsp_rdata 0x12345678, illegal 0 at N+3.
- CSRRS 0x300, src 0x8, csr_rd 0x80 -> wd 0x88; CSRRC same -> wd 0x80&~0x8 = 0x80; CSRRCI uimm 0x1F, old 0xFF -> wd 0xE0.
- CSRRS with uimm/rs1 index 0, old 0x1800 -> no csr_we, rsp_rdata 0x1800 at N+2.
- CSRRW to 0xF14 with CSR_RO_CHECK_EN -> rsp_illegal 1, rdata 0, no csr_we; without macro -> csr_we pulse, illegal 0. csr_hit=0 or op 100 -> illegal 1 in both builds.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready 0; release -> IDLE next cycle.
- Assert rst during READ of a CSRRW -> no csr_we ever, all outputs at reset values; next request completes normally.

Source files
------------

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write initiator between execute and the CSR file.
// Define CSR_RO_CHECK_EN to flag writes to the read-only CSR space (addr[11:10]==2'b11) as illegal.
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_src_i,
    input  logic [4:0]        req_uimm_i,
    input  logic              req_rd_zero_i,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic              csr_re_o,
    output logic              csr_we_o,
    output logic [XLEN-1:0]   csr_wd_o,
    input  logic [XLEN-1:0]   csr_rd_i,
    input  logic              csr_hit_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [XLEN-1:0]   rsp_rdata_o,
    output logic              rsp_illegal_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    state_e              state_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     operand_q;
    logic [4:0]          uimm_q;
    logic [XLEN-1:0]     old_q;
    logic                req_ready_q;
    logic [ADDR_W-1:0]   csr_addr_q;
    logic                csr_re_q;
    logic                csr_we_q;
    logic [XLEN-1:0]     csr_wd_q;
    logic                rsp_valid_q;
    logic [XLEN-1:0]     rsp_rdata_q;
    logic                rsp_illegal_q;

    logic                wr_en_d;
    logic                ro_viol_d;
    logic                illegal_d;
    logic [XLEN-1:0]     wdata_d;
    logic [XLEN-1:0]     operand_d;

    // Immediate forms (funct3[2]=1) take the zero-extended zimm as operand.
    assign operand_d = req_op_i[2] ? {{(XLEN-5){1'b0}}, req_uimm_i} : req_src_i;

    // Set/clear forms with a zero source register or zimm must not write.
    assign wr_en_d = (op_q[1:0] == 2'b01) ||
                     ((op_q[1:0] != 2'b00) && (uimm_q != 5'd0));

`ifdef CSR_RO_CHECK_EN
    assign ro_viol_d = wr_en_d && (csr_addr_q[ADDR_W-1 -: 2] == 2'b11);
`else
    assign ro_viol_d = 1'b0;
`endif

    assign illegal_d = (op_q[1:0] == 2'b00) || !csr_hit_i || ro_viol_d;

    always_comb begin
        wdata_d = '0;
        case (op_q[1:0])
            2'b01:   wdata_d = operand_q;
            2'b10:   wdata_d = csr_rd_i | operand_q;
            2'b11:   wdata_d = csr_rd_i & ~operand_q;
            default: wdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            op_q          <= '0;
            operand_q     <= '0;
            uimm_q        <= '0;
            old_q         <= '0;
            req_ready_q   <= 1'b1;
            csr_addr_q    <= '0;
            csr_re_q      <= 1'b0;
            csr_we_q      <= 1'b0;
            csr_wd_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q     <= READ;
                        op_q        <= req_op_i;
                        operand_q   <= operand_d;
                        uimm_q      <= req_uimm_i;
                        csr_addr_q  <= req_addr_i;
                        req_ready_q <= 1'b0;
                        csr_re_q    <= !((req_op_i[1:0] == 2'b01) && req_rd_zero_i);
                    end
                end
                READ: begin
                    csr_re_q <= 1'b0;
                    old_q    <= csr_rd_i;
                    if (wr_en_d && !illegal_d) begin
                        state_q  <= WRITE;
                        csr_we_q <= 1'b1;
                        csr_wd_q <= wdata_d;
                    end else begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= illegal_d ? '0 : csr_rd_i;
                        rsp_illegal_q <= illegal_d;
                    end
                end
                WRITE: begin
                    state_q       <= RESP;
                    csr_we_q      <= 1'b0;
                    csr_wd_q      <= '0;
                    rsp_valid_q   <= 1'b1;
                    rsp_rdata_q   <= old_q;
                    rsp_illegal_q <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_re_o      = csr_re_q;
    assign csr_we_o      = csr_we_q;
    assign csr_wd_o      = csr_wd_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit; expectations follow CSR_RO_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [11:0] req_addr = '0;
    logic [31:0] req_src = '0;
    logic [4:0]  req_uimm = '0;
    logic        req_rd_zero = 1'b0;
    logic [11:0] csr_addr;
    logic        csr_re;
    logic        csr_we;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd = '0;
    logic        csr_hit = 1'b1;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    int total = 0;
    int bad = 0;
    int weCount = 0;

    csr_access_unit #(.XLEN(32), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_src_i(req_src),
        .req_uimm_i(req_uimm), .req_rd_zero_i(req_rd_zero),
        .csr_addr_o(csr_addr), .csr_re_o(csr_re), .csr_we_o(csr_we),
        .csr_wd_o(csr_wd), .csr_rd_i(csr_rd), .csr_hit_i(csr_hit),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (csr_we === 1'b1) weCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                                 input logic [4:0] uimm, input logic rdZero, input logic [31:0] rd,
                                 input logic hit);
        req_valid   = 1'b1;
        req_op      = op;
        req_addr    = addr;
        req_src     = src;
        req_uimm    = uimm;
        req_rd_zero = rdZero;
        csr_rd      = rd;
        csr_hit     = hit;
    endtask

    // One full operation starting and ending at a negedge.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic [4:0] uimm, input logic rdZero,
                         input logic [31:0] rd, input logic hit, input logic expRe,
                         input logic expWe, input logic [31:0] expWd,
                         input logic [31:0] expRdata, input logic expIll, input int hold);
        int weBefore;
        weBefore = weCount;
        checkOutput({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        applyStimulus(op, addr, src, uimm, rdZero, rd, hit);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".csr_re"}, 32'(csr_re), 32'(expRe));
        checkOutput({tag, ".csr_addr"}, 32'(csr_addr), 32'(addr));
        @(negedge clk);
        if (expWe) begin
            checkOutput({tag, ".csr_we"}, 32'(csr_we), 32'd1);
            checkOutput({tag, ".csr_wd"}, csr_wd, expWd);
            checkOutput({tag, ".rsp_valid_early"}, 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, expRdata);
        checkOutput({tag, ".rsp_illegal"}, 32'(rsp_illegal), 32'(expIll));
        checkOutput({tag, ".csr_we_off"}, 32'(csr_we), 32'd0);
        checkOutput({tag, ".we_pulses"}, 32'(weCount - weBefore), expWe ? 32'd1 : 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, ".hold_rdata"}, rsp_rdata, expRdata);
            checkOutput({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".rsp_valid_done"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".req_ready_done"}, 32'(req_ready), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, ".rsp_illegal"}, 32'(rsp_illegal), 32'd0);
        checkOutput({tag, ".csr_re"}, 32'(csr_re), 32'd0);
        checkOutput({tag, ".csr_we"}, 32'(csr_we), 32'd0);
        checkOutput({tag, ".csr_wd"}, csr_wd, 32'd0);
        checkOutput({tag, ".csr_addr"}, 32'(csr_addr), 32'd0);
    endtask

    initial begin
        int weSnap;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        runOp("rw",   3'b001, 12'h340, 32'hDEADBEEF, 5'd5,    1'b0, 32'h12345678, 1'b1,
              1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0, 0);
        runOp("rs",   3'b010, 12'h300, 32'h00000008, 5'd3,    1'b0, 32'h00000080, 1'b1,
              1'b1, 1'b1, 32'h00000088, 32'h00000080, 1'b0, 0);
        runOp("rc",   3'b011, 12'h300, 32'h00000008, 5'd3,    1'b0, 32'h00000080, 1'b1,
              1'b1, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 0);
        runOp("rci",  3'b111, 12'h300, 32'h12345678, 5'h1F,   1'b0, 32'h000000FF, 1'b1,
              1'b1, 1'b1, 32'h000000E0, 32'h000000FF, 1'b0, 0);
        runOp("rs_x0", 3'b010, 12'h300, 32'h0000FFFF, 5'd0,   1'b0, 32'h00001800, 1'b1,
              1'b1, 1'b0, 32'h0, 32'h00001800, 1'b0, 0);
`ifdef CSR_RO_CHECK_EN
        runOp("ro_wr", 3'b001, 12'hF14, 32'h00000001, 5'd1,   1'b0, 32'h0000ABCD, 1'b1,
              1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 0);
`else
        runOp("ro_wr", 3'b001, 12'hF14, 32'h00000001, 5'd1,   1'b0, 32'h0000ABCD, 1'b1,
              1'b1, 1'b1, 32'h00000001, 32'h0000ABCD, 1'b0, 0);
`endif
        runOp("nohit", 3'b001, 12'h7C0, 32'h00000055, 5'd1,   1'b0, 32'h00000099, 1'b0,
              1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        runOp("op100", 3'b100, 12'h300, 32'h00000055, 5'd1,   1'b0, 32'h00000005, 1'b1,
              1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        runOp("rwi_x0", 3'b101, 12'h341, 32'hFFFFFFFF, 5'h15, 1'b1, 32'h00000077, 1'b1,
              1'b0, 1'b1, 32'h00000015, 32'h00000077, 1'b0, 0);
        runOp("stall", 3'b110, 12'h304, 32'h0, 5'd2,          1'b0, 32'h00000001, 1'b1,
              1'b1, 1'b1, 32'h00000003, 32'h00000001, 1'b0, 5);

        // Reset arrives while a CSRRW is in its READ cycle.
        weSnap = weCount;
        applyStimulus(3'b001, 12'h340, 32'hCAFEF00D, 5'd1, 1'b0, 32'h11111111, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid.csr_re_before", 32'(csr_re), 32'd1);
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid.no_write", 32'(weCount - weSnap), 32'd0);
        @(negedge clk);
        checkResetOutputs("rst_after");

        runOp("post_rst", 3'b001, 12'h340, 32'hA5A5A5A5, 5'd1, 1'b0, 32'h5A5A5A5A, 1'b1,
              1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
